mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data memory (DM), one transaction at a time.
// Optional starvation guard for fetch is compiled in with `define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_funct3,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg;  // 1 = DM owns the port
  logic        cmd_we_reg;
  logic [2:0]  cmd_funct3_reg;
  logic [31:0] cmd_addr_reg;
  logic [31:0] cmd_wdata_reg;
  logic        if_rvalid_reg, dm_rvalid_reg;
  logic [31:0] if_rdata_reg, dm_rdata_reg;
  logic        arb_go;
  logic        pick_dm;

  // Grants are combinational in IDLE and suppressed while reset is asserted.
  assign arb_go = (state_reg == IDLE) && reset && (if_req || dm_req);

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_reg;
  logic       starved;

  assign starved = (starve_cnt_reg >= 4'(STARVE_LIMIT));
  assign pick_dm = dm_req && !(if_req && starved);

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt_reg <= '0;
    end else if (arb_go) begin
      if (!pick_dm) begin
        starve_cnt_reg <= '0;
      end else if (if_req && (starve_cnt_reg != 4'hf)) begin
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end
    end
  end
`else
  logic unused_starve_limit;

  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign pick_dm             = dm_req;
`endif

  assign if_gnt = arb_go && !pick_dm;
  assign dm_gnt = arb_go && pick_dm;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_go) state_next = REQ;
      REQ:     if (mem_ready) state_next = WAIT;
      WAIT:    if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      cmd_we_reg     <= 1'b0;
      cmd_funct3_reg <= 3'b000;
      cmd_addr_reg   <= '0;
      cmd_wdata_reg  <= '0;
      if_rvalid_reg  <= 1'b0;
      dm_rvalid_reg  <= 1'b0;
      if_rdata_reg   <= '0;
      dm_rdata_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      if_rvalid_reg <= 1'b0;
      dm_rvalid_reg <= 1'b0;
      if (arb_go) begin
        owner_reg <= pick_dm;
        if (pick_dm) begin
          cmd_we_reg     <= dm_we;
          cmd_funct3_reg <= dm_funct3;
          cmd_addr_reg   <= dm_addr;
          cmd_wdata_reg  <= dm_wdata;
        end else begin
          cmd_we_reg     <= 1'b0;
          cmd_funct3_reg <= 3'b010;
          cmd_addr_reg   <= if_addr;
          cmd_wdata_reg  <= '0;
        end
      end
      // Write responses also land here; the data is simply passed through to DM.
      if ((state_reg == WAIT) && mem_rvalid) begin
        if (owner_reg) begin
          dm_rdata_reg  <= mem_rdata;
          dm_rvalid_reg <= 1'b1;
        end else begin
          if_rdata_reg  <= mem_rdata;
          if_rvalid_reg <= 1'b1;
        end
      end
    end
  end

  assign mem_req    = (state_reg == REQ);
  assign mem_we     = cmd_we_reg;
  assign mem_funct3 = cmd_funct3_reg;
  assign mem_addr   = cmd_addr_reg;
  assign mem_wdata  = cmd_wdata_reg;

  assign if_rvalid = if_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rvalid = dm_rvalid_reg;
  assign dm_rdata  = dm_rdata_reg;

  assign stall_f = if_req && !if_rvalid_reg;
  assign stall_m = dm_req && !dm_rvalid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected events/probes, a monitor compares them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_f, stall_m;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_IF_RV = 0, K_DM_RV = 1, K_IF_GNT = 2, K_DM_GNT = 3;
  localparam int P_STALL_F = 10, P_STALL_M = 11, P_MEM_REQ = 12, P_MEM_ADDR = 13, P_MEM_WE = 14,
                 P_MEM_WDATA = 15, P_MEM_F3 = 16, P_IF_RDATA = 17, P_DM_RDATA = 18,
                 P_IF_GNT = 19, P_DM_GNT = 20, P_IF_RV = 21, P_DM_RV = 22;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [5:0] GRANT_DM_CFG = 6'b101111;  // DM,DM,DM,DM,IF,DM
`else
  localparam logic [5:0] GRANT_DM_CFG = 6'b111111;  // DM wins every time
`endif

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } item_t;

  item_t       ev_tab [0:127];
  item_t       pr_tab [0:255];
  bit          pr_done [0:255];
  logic [31:0] rdata_tab [0:15];
  int          ev_n = 0, pr_n = 0, ev_rd = 0;
  int          n_vec = 0, n_fail = 0;
  int          ready_wait = 0, rv_delay = 1;
  bit          stim_done = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_IF_RV:     return "if_rvalid";
      K_DM_RV:     return "dm_rvalid";
      K_IF_GNT:    return "if_gnt";
      K_DM_GNT:    return "dm_gnt";
      P_STALL_F:   return "stall_f";
      P_STALL_M:   return "stall_m";
      P_MEM_REQ:   return "mem_req";
      P_MEM_ADDR:  return "mem_addr";
      P_MEM_WE:    return "mem_we";
      P_MEM_WDATA: return "mem_wdata";
      P_MEM_F3:    return "mem_funct3";
      P_IF_RDATA:  return "if_rdata";
      P_DM_RDATA:  return "dm_rdata";
      P_IF_GNT:    return "if_gnt_lvl";
      P_DM_GNT:    return "dm_gnt_lvl";
      P_IF_RV:     return "if_rvalid_lvl";
      P_DM_RV:     return "dm_rvalid_lvl";
      default:     return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] probe_val(input int k);
    case (k)
      P_STALL_F:   return {31'd0, stall_f};
      P_STALL_M:   return {31'd0, stall_m};
      P_MEM_REQ:   return {31'd0, mem_req};
      P_MEM_ADDR:  return mem_addr;
      P_MEM_WE:    return {31'd0, mem_we};
      P_MEM_WDATA: return mem_wdata;
      P_MEM_F3:    return {29'd0, mem_funct3};
      P_IF_RDATA:  return if_rdata;
      P_DM_RDATA:  return dm_rdata;
      P_IF_GNT:    return {31'd0, if_gnt};
      P_DM_GNT:    return {31'd0, dm_gnt};
      P_IF_RV:     return {31'd0, if_rvalid};
      P_DM_RV:     return {31'd0, dm_rvalid};
      default:     return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic push_ev(input int kind, input int at, input logic [31:0] val);
    ev_tab[ev_n].cyc  = at;
    ev_tab[ev_n].kind = kind;
    ev_tab[ev_n].val  = val;
    ev_n++;
  endtask

  task automatic push_pr(input int kind, input int at, input logic [31:0] val);
    pr_tab[pr_n].cyc  = at;
    pr_tab[pr_n].kind = kind;
    pr_tab[pr_n].val  = val;
    pr_n++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory model: mem_ready after ready_wait REQ cycles, mem_rvalid rv_delay cycles later.
  initial begin : responder
    int wait_cnt;
    int rv_cnt;
    int resp_idx;
    wait_cnt = 0; rv_cnt = 0; resp_idx = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (rv_cnt == 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata_tab[resp_idx];
        resp_idx++;
        rv_cnt = 0;
      end else if (rv_cnt > 1) begin
        rv_cnt--;
      end else if (mem_req) begin
        if (wait_cnt < ready_wait) begin
          wait_cnt++;
        end else begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
          rv_cnt    = rv_delay;
        end
      end
    end
  end

  task automatic check_ev(input logic fired, input int kind, input logic [31:0] data);
    if (fired) begin
      n_vec++;
      if (ev_rd >= ev_n) begin
        n_fail++;
        $display("FAIL %s unexpected at cycle %0d data=%h, required none", kname(kind), cyc, data);
      end else begin
        if (ev_tab[ev_rd].kind != kind || ev_tab[ev_rd].cyc != cyc || ev_tab[ev_rd].val != data) begin
          n_fail++;
          $display("FAIL %s got cycle=%0d data=%h, required %s cycle=%0d data=%h", kname(kind), cyc, data,
                   kname(ev_tab[ev_rd].kind), ev_tab[ev_rd].cyc, ev_tab[ev_rd].val);
        end else begin
          $display("txn cycle=%0d %s data=%h ok", cyc, kname(kind), data);
        end
        ev_rd++;
      end
    end
  endtask

  initial begin : monitor
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        while (ev_rd < ev_n && ev_tab[ev_rd].cyc < cyc) begin
          n_vec++; n_fail++;
          $display("FAIL %s missing: required at cycle %0d data=%h", kname(ev_tab[ev_rd].kind),
                   ev_tab[ev_rd].cyc, ev_tab[ev_rd].val);
          ev_rd++;
        end
        check_ev(if_rvalid, K_IF_RV, if_rdata);
        check_ev(dm_rvalid, K_DM_RV, dm_rdata);
        check_ev(if_gnt, K_IF_GNT, 32'd0);
        check_ev(dm_gnt, K_DM_GNT, 32'd0);
        for (int i = 0; i < pr_n; i++) begin
          if (!pr_done[i] && pr_tab[i].cyc <= cyc) begin
            pr_done[i] = 1'b1;
            n_vec++;
            act = probe_val(pr_tab[i].kind);
            if (pr_tab[i].cyc < cyc) begin
              n_fail++;
              $display("FAIL %s probe for cycle %0d not sampled", kname(pr_tab[i].kind), pr_tab[i].cyc);
            end else if (act !== pr_tab[i].val) begin
              n_fail++;
              $display("FAIL %s at cycle %0d got %h, required %h", kname(pr_tab[i].kind), cyc, act, pr_tab[i].val);
            end
          end
        end
      end
      if (stim_done) begin
        while (ev_rd < ev_n) begin
          n_vec++; n_fail++;
          $display("FAIL %s missing: required at cycle %0d data=%h", kname(ev_tab[ev_rd].kind),
                   ev_tab[ev_rd].cyc, ev_tab[ev_rd].val);
          ev_rd++;
        end
        for (int i = 0; i < pr_n; i++) begin
          if (!pr_done[i]) begin
            n_vec++; n_fail++;
            $display("FAIL %s probe for cycle %0d never reached", kname(pr_tab[i].kind), pr_tab[i].cyc);
          end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
      end
    end
  end

  initial begin : stimulus
    int c;
    logic [5:0] grant_dm;
    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_funct3 = 3'b000; dm_addr = '0; dm_wdata = '0;
    rdata_tab[0] = 32'h0050_0093; rdata_tab[1] = 32'h0000_0013;
    rdata_tab[2] = 32'h1111_1111; rdata_tab[3] = 32'h2222_2222;
    rdata_tab[4] = 32'h3333_3333; rdata_tab[5] = 32'h4444_4444;
    rdata_tab[6] = 32'h6666_6666; rdata_tab[7] = 32'h7777_7777;
    for (int j = 0; j < 8; j++) rdata_tab[8 + j] = 32'h80 + 32'(j);

    // Reset: requests present but nothing granted, everything cleared.
    step(2); c = cyc;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h5555_0000; dm_wdata = 32'h1234_5678;
    push_pr(P_IF_GNT, c, 0); push_pr(P_DM_GNT, c, 0); push_pr(P_MEM_REQ, c, 0);
    push_pr(P_IF_RV, c, 0); push_pr(P_DM_RV, c, 0); push_pr(P_IF_RDATA, c, 0); push_pr(P_DM_RDATA, c, 0);
    push_pr(P_MEM_ADDR, c, 0); push_pr(P_MEM_WDATA, c, 0); push_pr(P_STALL_F, c, 1); push_pr(P_STALL_M, c, 1);
    step(1); reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;

    // IF-only read, then a back-to-back fetch granted in the rvalid cycle.
    step(1); c = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    push_ev(K_IF_GNT, c, 0); push_ev(K_IF_RV, c + 3, 32'h0050_0093);
    push_ev(K_IF_GNT, c + 3, 0); push_ev(K_IF_RV, c + 6, 32'h0000_0013);
    push_pr(P_STALL_F, c, 1); push_pr(P_MEM_REQ, c + 1, 1); push_pr(P_MEM_ADDR, c + 1, 32'h100);
    push_pr(P_MEM_WE, c + 1, 0); push_pr(P_MEM_F3, c + 1, 2); push_pr(P_MEM_WDATA, c + 1, 0);
    push_pr(P_MEM_REQ, c + 2, 0); push_pr(P_STALL_F, c + 2, 1); push_pr(P_STALL_F, c + 3, 0);
    push_pr(P_IF_RDATA, c + 3, 32'h0050_0093); push_pr(P_DM_RV, c + 3, 0); push_pr(P_MEM_ADDR, c + 4, 32'h104);
    step(1); if_addr = 32'h104;
    step(3); if_req = 1'b0;
    step(4);

    // Simultaneous requests: DM store first, IF granted in the dm_rvalid cycle.
    c = cyc;
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = 3'b010; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
    push_ev(K_DM_GNT, c, 0); push_ev(K_DM_RV, c + 3, 32'h1111_1111);
    push_ev(K_IF_GNT, c + 3, 0); push_ev(K_IF_RV, c + 6, 32'h2222_2222);
    push_pr(P_MEM_REQ, c + 1, 1); push_pr(P_MEM_WE, c + 1, 1); push_pr(P_MEM_ADDR, c + 1, 32'h2000);
    push_pr(P_MEM_WDATA, c + 1, 32'hDEAD_BEEF); push_pr(P_MEM_F3, c + 1, 2);
    for (int k = 0; k < 4; k++) push_pr(P_STALL_F, c + k, 1);
    push_pr(P_STALL_M, c + 2, 1); push_pr(P_DM_RDATA, c + 3, 32'h1111_1111);
    push_pr(P_MEM_ADDR, c + 4, 32'h200); push_pr(P_MEM_WE, c + 4, 0); push_pr(P_MEM_WDATA, c + 4, 0);
    step(3); dm_req = 1'b0; dm_we = 1'b0;
    step(1); if_req = 1'b0;
    step(4);

    // mem_ready withheld for 5 REQ cycles; a late IF request and DM field changes must not leak in.
    c = cyc; ready_wait = 5;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b100; dm_addr = 32'h3004; dm_wdata = 32'hCAFE_F00D;
    push_ev(K_DM_GNT, c, 0); push_ev(K_DM_RV, c + 8, 32'h3333_3333);
    push_ev(K_IF_GNT, c + 8, 0); push_ev(K_IF_RV, c + 11, 32'h4444_4444);
    for (int k = 1; k <= 6; k++) begin
      push_pr(P_MEM_REQ, c + k, 1); push_pr(P_MEM_ADDR, c + k, 32'h3004);
      push_pr(P_MEM_F3, c + k, 4); push_pr(P_MEM_WDATA, c + k, 32'hCAFE_F00D); push_pr(P_STALL_M, c + k, 1);
    end
    push_pr(P_MEM_REQ, c + 7, 0); push_pr(P_STALL_F, c + 5, 1); push_pr(P_DM_RV, c + 7, 0);
    push_pr(P_MEM_ADDR, c + 9, 32'h400);
    step(2); if_req = 1'b1; if_addr = 32'h400;
    step(1); dm_addr = 32'h3FFC; dm_funct3 = 3'b000;
    step(4); ready_wait = 0;
    step(1); dm_req = 1'b0;
    step(1); if_req = 1'b0;
    step(4);

    // Reset during WAIT; the stale mem_rvalid one cycle after release is dropped.
    c = cyc; rv_delay = 3;
    if_req = 1'b1; if_addr = 32'h500;
    push_ev(K_IF_GNT, c, 0);
    push_pr(P_MEM_REQ, c + 1, 1); push_pr(P_MEM_REQ, c + 2, 0); push_pr(P_MEM_REQ, c + 3, 0);
    push_pr(P_MEM_REQ, c + 4, 0); push_pr(P_IF_RDATA, c + 3, 0); push_pr(P_MEM_ADDR, c + 3, 0);
    push_pr(P_IF_RDATA, c + 5, 0); push_pr(P_IF_RV, c + 5, 0);
    step(2); reset = 1'b0; if_req = 1'b0;
    step(1); reset = 1'b1;
    step(2); rv_delay = 1;
    step(1); c = cyc;
    if_req = 1'b1; if_addr = 32'h600;
    push_ev(K_IF_GNT, c, 0); push_ev(K_IF_RV, c + 3, 32'h7777_7777);
    push_pr(P_MEM_ADDR, c + 1, 32'h600);
    step(1); if_req = 1'b0;
    step(4);

    // Both requesters held: grant order depends on the starvation guard.
    c = cyc; grant_dm = GRANT_DM_CFG;
    if_req = 1'b1; if_addr = 32'h700;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b010; dm_addr = 32'h4000; dm_wdata = '0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) push_ev(grant_dm[j - 1] ? K_DM_RV : K_IF_RV, c + 3 * j, 32'h80 + 32'(j - 1));
      push_ev(grant_dm[j] ? K_DM_GNT : K_IF_GNT, c + 3 * j, 0);
    end
    push_ev(grant_dm[5] ? K_DM_RV : K_IF_RV, c + 18, 32'h85);
    push_pr(P_MEM_ADDR, c + 13, grant_dm[4] ? 32'h4000 : 32'h700);
    push_pr(P_STALL_F, c + 14, 1);
    step(16); if_req = 1'b0; dm_req = 1'b0;
    step(4);

    stim_done = 1'b1;
  end

endmodule
